pwm_multich: RTL and testbench

- N-channel PWM generator: the next generation of the single-channel duty/POW2/POW5 PWM driven by the UART command front end.
- Each channel has its own duty and its own period prescale. Period is BASE_PERIOD·2^pow2·5^pow5 clocks.
- Settings are double-buffered: shadow registers are written at any time and loaded glitch-free at that channel's period boundary.
- Adds a global counter-sync strobe and 100 % duty support.
- Sits between the command parser (register-write port) and the pads.

---
 rtl/pwm_multich.sv | 153 +++++++++++++++
 tb/tb_pwm_multich.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multich.sv
`timescale 1ns/1ps
// N-channel double-buffered PWM; write response one cycle after wr_en, pwm_o lags the counter by one clock.
// No backpressure: every write strobe is accepted or rejected with a fixed one-cycle response.
module pwm_multich #(
    parameter int N_CH        = 4,
    parameter int BASE_PERIOD = 1000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [6:0]        wr_data,
    output logic              wr_ok_o,
    output logic              wr_err_o,
    input  logic              sync_i,
    output logic [N_CH-1:0]   pwm_o,
    output logic [N_CH-1:0]   eop_o
);

    localparam int UNIT = BASE_PERIOD / 100;

    typedef enum logic {ST_OFF, ST_RUN} ch_state_t;

    // Prescale factor 2^pow2 * 5^pow5 built from shifts and a small table.
    function automatic logic [31:0] scale(input logic [1:0] p2, input logic [1:0] p5);
        logic [31:0] f5;
        case (p5)
            2'd0:    f5 = 32'd1;
            2'd1:    f5 = 32'd5;
            2'd2:    f5 = 32'd25;
            default: f5 = 32'd125;
        endcase
        return f5 << p2;
    endfunction

    logic wr_valid;

    always_comb begin
        wr_valid = ({1'b0, wr_ch} < 5'(N_CH));
        case (wr_sel)
            2'd0:       if (wr_data > 7'd100) wr_valid = 1'b0;
            2'd1, 2'd2: if (wr_data > 7'd3)   wr_valid = 1'b0;
            default:    if (wr_data > 7'd1)   wr_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ok_o  <= 1'b0;
            wr_err_o <= 1'b0;
        end else begin
            wr_ok_o  <= wr_en && wr_valid;
            wr_err_o <= wr_en && !wr_valid;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [6:0]       sh_duty;
        logic [1:0]       sh_pow2;
        logic [1:0]       sh_pow5;
        logic             sh_en;
        logic             wr_hit;
        logic [31:0]      sc;
        logic [31:0]      p_full;
        logic [31:0]      h_full;
        logic [CNT_W-1:0] sh_pm1;
        logic [CNT_W-1:0] sh_high;

        ch_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] pm1_q, pm1_d;
        logic [CNT_W-1:0] high_q, high_d;
        logic             pwm_q, pwm_d;

        assign wr_hit = wr_en && wr_valid && (wr_ch == 4'(g));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sh_duty <= '0;
                sh_pow2 <= '0;
                sh_pow5 <= '0;
                sh_en   <= 1'b0;
            end else if (wr_hit) begin
                case (wr_sel)
                    2'd0:    sh_duty <= wr_data;
                    2'd1:    sh_pow2 <= wr_data[1:0];
                    2'd2:    sh_pow5 <= wr_data[1:0];
                    default: sh_en   <= wr_data[0];
                endcase
            end
        end

        // Period and high time are precomputed from the shadows so a load is a plain register copy.
        assign sc      = scale(sh_pow2, sh_pow5);
        assign p_full  = 32'(BASE_PERIOD) * sc;
        assign h_full  = 32'(sh_duty) * 32'(UNIT) * sc;
        assign sh_pm1  = CNT_W'(p_full - 32'd1);
        assign sh_high = CNT_W'(h_full);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
                pm1_q   <= '0;
                high_q  <= '0;
                pwm_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pm1_q   <= pm1_d;
                high_q  <= high_d;
                pwm_q   <= pwm_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pm1_d   = pm1_q;
            high_d  = high_q;
            pwm_d   = 1'b0;
            case (state_q)
                ST_OFF: begin
                    if (sh_en) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        pm1_d   = sh_pm1;
                        high_d  = sh_high;
                    end
                end
                ST_RUN: begin
                    pwm_d = (cnt_q < high_q);
                    // Boundary and sync share the load; a same-cycle write lands after it.
                    if (sync_i || (cnt_q == pm1_q)) begin
                        cnt_d   = '0;
                        pm1_d   = sh_pm1;
                        high_d  = sh_high;
                        state_d = sh_en ? ST_RUN : ST_OFF;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        assign pwm_o[g] = pwm_q;
        assign eop_o[g] = (state_q == ST_RUN) && (cnt_q == pm1_q);
    end

endmodule

// File: tb/tb_pwm_multich.sv
`timescale 1ns/1ps
// Directed bench for pwm_multich with BASE_PERIOD=100 to keep runs short.
module tb_pwm_multich;
    localparam int N_CH  = 4;
    localparam int BASE  = 100;
    localparam int LIMIT = 20000;

    logic            clk = 1'b0;
    logic            rstn;
    logic            wr_en;
    logic [3:0]      wr_ch;
    logic [1:0]      wr_sel;
    logic [6:0]      wr_data;
    logic            wr_ok_o;
    logic            wr_err_o;
    logic            sync_i;
    logic [N_CH-1:0] pwm_o;
    logic [N_CH-1:0] eop_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multich #(.N_CH(N_CH), .BASE_PERIOD(BASE), .CNT_W(20)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .wr_ok_o  (wr_ok_o),
        .wr_err_o (wr_err_o),
        .sync_i   (sync_i),
        .pwm_o    (pwm_o),
        .eop_o    (eop_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge after checking the response.
    task automatic wr(input logic [3:0] ch, input logic [1:0] sel, input logic [6:0] data, input bit exp_ok);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_sel  = sel;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_ok", 32'(wr_ok_o), 32'(exp_ok));
        chk("wr_err", 32'(wr_err_o), 32'(!exp_ok));
    endtask

    // Measures one period from a rising edge; at_rise means the current sample is already the first high one.
    task automatic measure(input int ch, input bit at_rise, output int hi, output int per);
        int n;
        int lo;
        hi  = -1;
        per = -1;
        n   = 0;
        if (!at_rise) begin
            while (pwm_o[ch] !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
            while (pwm_o[ch] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
            if (n >= LIMIT) return;
        end
        hi = 0;
        lo = 0;
        while (pwm_o[ch] === 1'b1 && hi < LIMIT) begin hi++; @(negedge clk); end
        while (pwm_o[ch] === 1'b0 && lo < LIMIT) begin lo++; @(negedge clk); end
        if (lo < LIMIT) per = hi + lo;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int h, p, cnt_hi, cnt_lo, cnt_eop, m0, m2, n;

        rstn = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0; sync_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm_o), 0);
        chk("rst_eop", 32'(eop_o), 0);
        chk("rst_ok", 32'(wr_ok_o), 0);
        chk("rst_err", 32'(wr_err_o), 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_pwm", 32'(pwm_o), 0);

        // ch0: duty 50, base period
        wr(0, 0, 50, 1);
        wr(0, 1, 0, 1);
        wr(0, 2, 0, 1);
        wr(0, 3, 1, 1);
        measure(0, 0, h, p);
        chk("ch0_high", h, 50);
        chk("ch0_period", p, 100);
        chk("ch321_low", 32'(pwm_o[3:1]), 0);
        cnt_eop = 0;
        for (int k = 0; k < 300; k++) begin cnt_eop += int'(eop_o[0]); @(negedge clk); end
        chk("ch0_eop_cnt", cnt_eop, 3);

        // ch1: period 100*2*25 = 5000, duty 25 then 75 written mid-period
        wr(1, 0, 25, 1);
        wr(1, 1, 1, 1);
        wr(1, 2, 2, 1);
        wr(1, 3, 1, 1);
        measure(1, 0, h, p);
        chk("ch1_high_a", h, 1250);
        chk("ch1_period_a", p, 5000);
        fork
            wr(1, 0, 75, 1);
            measure(1, 1, h, p);
        join
        chk("ch1_high_b", h, 1250);
        chk("ch1_period_b", p, 5000);
        measure(1, 1, h, p);
        chk("ch1_high_c", h, 3750);
        chk("ch1_period_c", p, 5000);

        // Rejected writes leave ch0 at duty 50
        wr(0, 0, 101, 0);
        wr(0, 1, 4, 0);
        wr(0, 2, 4, 0);
        wr(5, 0, 10, 0);
        wr(4, 0, 10, 0);
        wr(0, 3, 2, 0);
        repeat (120) @(negedge clk);
        measure(0, 0, h, p);
        chk("ch0_kept_high", h, 50);
        chk("ch0_kept_period", p, 100);

        // duty 0 and duty 100 on ch0
        wr(0, 0, 0, 1);
        repeat (250) @(negedge clk);
        cnt_hi = 0; cnt_eop = 0;
        for (int k = 0; k < 300; k++) begin
            cnt_hi += int'(pwm_o[0]); cnt_eop += int'(eop_o[0]); @(negedge clk);
        end
        chk("duty0_high", cnt_hi, 0);
        chk("duty0_eop", cnt_eop, 3);
        wr(0, 0, 100, 1);
        repeat (150) @(negedge clk);
        cnt_lo = 0; cnt_eop = 0;
        for (int k = 0; k < 300; k++) begin
            cnt_lo += int'(!pwm_o[0]); cnt_eop += int'(eop_o[0]); @(negedge clk);
        end
        chk("duty100_low", cnt_lo, 0);
        chk("duty100_eop", cnt_eop, 3);

        // sync: ch0 period 200, ch2 period 400, both duty 50
        wr(0, 0, 50, 1);
        wr(0, 1, 1, 1);
        wr(2, 0, 50, 1);
        wr(2, 1, 2, 1);
        wr(2, 3, 1, 1);
        repeat ($urandom_range(600, 100)) @(negedge clk);
        sync_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
        @(negedge clk);
        m0 = 0; m2 = 0;
        for (int k = 0; k < 800; k++) begin
            if (pwm_o[0] !== ((k % 200) < 100)) m0++;
            if (pwm_o[2] !== ((k % 400) < 200)) m2++;
            @(negedge clk);
        end
        chk("sync_ch0_pattern", m0, 0);
        chk("sync_ch2_pattern", m2, 0);

        // ch3: period 800, write landing on the eop cycle applies one period later
        wr(3, 0, 10, 1);
        wr(3, 1, 3, 1);
        wr(3, 3, 1, 1);
        n = 0;
        while (eop_o[3] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("ch3_eop_seen", 32'(eop_o[3]), 1);
        wr(3, 0, 30, 1);
        measure(3, 0, h, p);
        chk("ch3_high_old", h, 80);
        chk("ch3_period", p, 800);
        measure(3, 1, h, p);
        chk("ch3_high_new", h, 240);

        // Disable mid-high: the running period completes, then stays low
        cnt_hi = 0; cnt_eop = 0;
        fork
            begin
                repeat (50) @(negedge clk);
                wr(3, 3, 0, 1);
            end
            for (int k = 0; k < 1600; k++) begin
                cnt_hi += int'(pwm_o[3]); cnt_eop += int'(eop_o[3]); @(negedge clk);
            end
        join
        chk("ch3_dis_high", cnt_hi, 240);
        chk("ch3_dis_eop", cnt_eop, 1);
        chk("ch3_dis_low", 32'(pwm_o[3]), 0);

        // Asynchronous reset while ch1 is high
        n = 0;
        while (pwm_o[1] !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
        chk("ch1_high_before_rst", 32'(pwm_o[1]), 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_o), 0);
        chk("async_rst_eop", 32'(eop_o), 0);
        @(negedge clk);
        rstn = 1'b1;
        cnt_hi = 0; cnt_eop = 0;
        for (int k = 0; k < 1000; k++) begin
            cnt_hi += int'(|pwm_o); cnt_eop += int'(|eop_o); @(negedge clk);
        end
        chk("post_rst_pwm", cnt_hi, 0);
        chk("post_rst_eop", cnt_eop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
